// File: rtl/sm83_pkg.sv
// sm83_pkg: types and constants shared across the sm83 core.
//   s_db_t      - 8-bit data bus byte
//   s_addr_t    - 16-bit memory address
//   seq_state_t - fetch sequencer state (RUN, PREFIX, HALT)
//   OPC_*       - opcodes the sequencer treats specially
package sm83_pkg;

  typedef logic [7:0]  s_db_t;
  typedef logic [15:0] s_addr_t;

  typedef enum logic [1:0] {
    SEQ_RUN    = 2'd0,
    SEQ_PREFIX = 2'd1,
    SEQ_HALT   = 2'd2
  } seq_state_t;

  localparam s_db_t OPC_NOP  = 8'h00;
  localparam s_db_t OPC_CB   = 8'hCB;
  localparam s_db_t OPC_HALT = 8'h76;

endpackage

// File: rtl/sm83_fetch.sv
// sm83_fetch: instruction-fetch and M-cycle sequencer for the sm83 core.
// Performs the overlapped opcode fetch (next opcode is read during the last
// M-cycle of the current instruction), CB-prefix fetch and HALT.
// Ports:
//   clk, reset        - clock (one edge per T-cycle), sync active-high reset
//   d_in              - memory read data, sampled at T4
//   addr_in           - datapath address for non-fetch M-cycles
//   last_m            - decoder: current M-cycle is the instruction's last
//   pc_load, pc_new   - load PC with a jump/call/return target at T4
//   halt, irq_pending - current op is HALT / enabled interrupt pending
//   mem_addr, mem_rd  - memory address and read strobe (combinational)
//   pc, ir, cb        - program counter, current opcode, CB-prefixed flag
//   m_cycle, t_phase  - M-cycle index and T-cycle within the M-cycle
//   halted            - sequencer is in HALT
module sm83_fetch
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MAX_M    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  d_in,
  input  logic [15:0] addr_in,
  input  logic        last_m,
  input  logic        pc_load,
  input  logic [15:0] pc_new,
  input  logic        halt,
  input  logic        irq_pending,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] pc,
  output logic [7:0]  ir,
  output logic        cb,
  output logic [2:0]  m_cycle,
  output logic [1:0]  t_phase,
  output logic        halted
);

  seq_state_t state;
  logic       t4;
  s_addr_t    pc_inc;
  logic [2:0] m_next;

  assign t4     = (t_phase == 2'd3);
  assign pc_inc = pc + 16'd1;
  assign m_next = (m_cycle == 3'(MAX_M)) ? m_cycle : m_cycle + 3'd1;
  assign halted = (state == SEQ_HALT);

  // Fetch cycles drive PC; datapath M-cycles use the datapath's address
  // and own their read strobe.
  always_comb begin
    mem_addr = pc;
    mem_rd   = 1'b0;
    case (state)
      SEQ_PREFIX: mem_rd = 1'b1;
      SEQ_RUN: begin
        if (last_m) begin
          mem_rd = 1'b1;
        end else begin
          mem_addr = addr_in;
        end
      end
      default: mem_rd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEQ_RUN;
      pc      <= RESET_PC;
      ir      <= OPC_NOP;
      cb      <= 1'b0;
      m_cycle <= 3'd0;
      t_phase <= 2'd0;
    end else begin
      t_phase <= t_phase + 2'd1;
      if (t4) begin
        case (state)
          SEQ_RUN: begin
            if (!last_m) begin
              m_cycle <= m_next;
              if (pc_load) pc <= pc_new;
            end else if (halt && !irq_pending) begin
              state <= SEQ_HALT;
            end else begin
              // Opcode commit; a simultaneous pc_load overrides the increment.
              ir      <= d_in;
              cb      <= 1'b0;
              m_cycle <= 3'd0;
              pc      <= pc_load ? pc_new : pc_inc;
              if (d_in == OPC_CB) state <= SEQ_PREFIX;
            end
          end
          SEQ_PREFIX: begin
            // Second byte always commits as a CB opcode, never re-prefixes.
            ir      <= d_in;
            cb      <= 1'b1;
            pc      <= pc_inc;
            m_cycle <= 3'd0;
            state   <= SEQ_RUN;
          end
          SEQ_HALT: begin
            // Wake into a forced NOP whose last M-cycle refetches at pc.
            if (irq_pending) begin
              ir      <= OPC_NOP;
              m_cycle <= 3'd0;
              state   <= SEQ_RUN;
            end
          end
          default: state <= SEQ_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm83_fetch.sv
// tb_sm83_fetch: table-driven bench for sm83_fetch. Each table row is one
// M-cycle: the decoder/memory inputs, the expected combinational address
// and strobe, and the expected registered state after that M-cycle's T4.
module tb_sm83_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  d_in;
  logic [15:0] addr_in;
  logic        last_m;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        halt;
  logic        irq_pending;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] pc;
  logic [7:0]  ir;
  logic        cb;
  logic [2:0]  m_cycle;
  logic [1:0]  t_phase;
  logic        halted;

  sm83_fetch dut (
    .clk(clk), .reset(reset), .d_in(d_in), .addr_in(addr_in),
    .last_m(last_m), .pc_load(pc_load), .pc_new(pc_new), .halt(halt),
    .irq_pending(irq_pending), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .pc(pc), .ir(ir), .cb(cb), .m_cycle(m_cycle), .t_phase(t_phase),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lm;
    logic        pl;
    logic [15:0] pnew;
    logic        hlt;
    logic        irq;
    logic [15:0] ain;
    logic [7:0]  din;
    logic [15:0] eaddr;
    logic        erd;
    logic [15:0] epc;
    logic [7:0]  eir;
    logic        ecb;
    logic [2:0]  em;
    logic        eh;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  ir;
    logic        cb;
    logic [2:0]  m;
    logic        h;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   npass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic lm, input logic pl, input logic [15:0] pnew,
    input logic hlt, input logic irq, input logic [15:0] ain,
    input logic [7:0] din, input logic [15:0] eaddr, input logic erd,
    input logic [15:0] epc, input logic [7:0] eir, input logic ecb,
    input logic [2:0] em, input logic eh);
    vec_t v;
    v.lm = lm; v.pl = pl; v.pnew = pnew; v.hlt = hlt; v.irq = irq;
    v.ain = ain; v.din = din; v.eaddr = eaddr; v.erd = erd;
    v.epc = epc; v.eir = eir; v.ecb = ecb; v.em = em; v.eh = eh;
    return v;
  endfunction

  initial begin
    vec_t        v;
    exp_t        e;
    logic [15:0] prev_pc;

    //                lm pl pnew      hl irq ain       din    eaddr     rd pc        ir     cb m     h
    // Reset-NOP stream: pc 1, 2, 3
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 16'h0000, 1, 16'h0001, 8'h00, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 16'h0001, 1, 16'h0002, 8'h00, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 16'h0002, 1, 16'h0003, 8'h00, 0, 3'd0, 0));
    // CB 37; in PREFIX last_m/pc_load/halt are ignored
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'hCB, 16'h0003, 1, 16'h0004, 8'hCB, 0, 3'd0, 0));
    vecs.push_back(mk(0, 1, 16'h5555, 1, 0, 16'hC000, 8'h37, 16'h0004, 1, 16'h0005, 8'h37, 1, 3'd0, 0));
    // Two datapath M-cycles then commit
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'hC000, 8'h00, 16'hC000, 0, 16'h0005, 8'h37, 1, 3'd1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'hC000, 8'h00, 16'hC000, 0, 16'h0005, 8'h37, 1, 3'd2, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'hC000, 8'h00, 16'h0005, 1, 16'h0006, 8'h00, 0, 3'd0, 0));
    // Jump to 1234 at T4 of M1, fetch in M2
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'hC001, 8'h00, 16'hC001, 0, 16'h0006, 8'h00, 0, 3'd1, 0));
    vecs.push_back(mk(0, 1, 16'h1234, 0, 0, 16'hC002, 8'h00, 16'hC002, 0, 16'h1234, 8'h00, 0, 3'd2, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h3E, 16'h1234, 1, 16'h1235, 8'h3E, 0, 3'd0, 0));
    // Move to 0100, then HALT with no interrupt
    vecs.push_back(mk(0, 1, 16'h0100, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 16'h0100, 8'h3E, 0, 3'd1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 8'h00, 16'h0100, 1, 16'h0100, 8'h3E, 0, 3'd1, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 16'h0100, 0, 16'h0100, 8'h3E, 0, 3'd1, 1));
    // Wake: forced NOP, then refetch at 0100
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0000, 8'h99, 16'h0100, 0, 16'h0100, 8'h00, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 16'h0100, 1, 16'h0101, 8'h00, 0, 3'd0, 0));
    // HALT with interrupt pending falls through
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0000, 8'h00, 16'h0101, 1, 16'h0102, 8'h00, 0, 3'd0, 0));
    // pc_load with last_m: load wins, opcode still committed
    vecs.push_back(mk(1, 1, 16'hFFFF, 0, 0, 16'h0000, 8'hAA, 16'h0102, 1, 16'hFFFF, 8'hAA, 0, 3'd0, 0));
    // PC wrap FFFF -> 0000
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 16'hFFFF, 1, 16'h0000, 8'h00, 0, 3'd0, 0));
    // m_cycle saturation at MAX_M
    for (int k = 1; k <= 6; k++) begin
      vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h8000, 8'h00, 16'h8000, 0, 16'h0000, 8'h00, 0,
                        (k > 5) ? 3'd5 : 3'(k), 0));
    end
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 16'h0000, 1, 16'h0001, 8'h00, 0, 3'd0, 0));
    // CB CB is SET 1,E, not a re-prefix: back in RUN afterwards
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 8'hCB, 16'h0001, 1, 16'h0002, 8'hCB, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h9000, 8'hCB, 16'h0002, 1, 16'h0003, 8'hCB, 1, 3'd0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h9000, 8'h00, 16'h9000, 0, 16'h0003, 8'hCB, 1, 3'd1, 0));

    // Reset
    reset = 1'b1; d_in = 8'h00; addr_in = 16'h0000; last_m = 1'b1;
    pc_load = 1'b0; pc_new = 16'h0000; halt = 1'b0; irq_pending = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_ir", 32'(ir), 32'h00);
    chk("rst_cb", 32'(cb), 32'h0);
    chk("rst_m", 32'(m_cycle), 32'h0);
    chk("rst_t", 32'(t_phase), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    prev_pc = 16'h0000;

    foreach (vecs[i]) begin
      v = vecs[i];
      last_m = v.lm; pc_load = v.pl; pc_new = v.pnew; halt = v.hlt;
      irq_pending = v.irq; addr_in = v.ain; d_in = v.din;
      #1;
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(v.eaddr));
      chk($sformatf("v%0d_rd", i), 32'(mem_rd), 32'(v.erd));
      e.pc = v.epc; e.ir = v.eir; e.cb = v.ecb; e.m = v.em; e.h = v.eh;
      sb.push_back(e);
      step(); step(); step();
      chk($sformatf("v%0d_t3", i), 32'(t_phase), 32'h3);
      chk($sformatf("v%0d_pc_hold", i), 32'(pc), 32'(prev_pc));
      step();
      if (sb.size() == 0) begin
        chk("sb_empty", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_pc", i), 32'(pc), 32'(e.pc));
        chk($sformatf("v%0d_ir", i), 32'(ir), 32'(e.ir));
        chk($sformatf("v%0d_cb", i), 32'(cb), 32'(e.cb));
        chk($sformatf("v%0d_m", i), 32'(m_cycle), 32'(e.m));
        chk($sformatf("v%0d_halted", i), 32'(halted), 32'(e.h));
        chk($sformatf("v%0d_t0", i), 32'(t_phase), 32'h0);
        prev_pc = e.pc;
      end
    end

    // Mid-instruction reset at t_phase 2 of M3
    last_m = 1'b0; pc_load = 1'b0; halt = 1'b0; irq_pending = 1'b0;
    addr_in = 16'h7000;
    repeat (8) step();
    chk("pre_rst_m", 32'(m_cycle), 32'h3);
    step(); step();
    chk("pre_rst_t", 32'(t_phase), 32'h2);
    reset = 1'b1;
    last_m = 1'b1;
    step();
    chk("mid_rst_pc", 32'(pc), 32'h0000);
    chk("mid_rst_ir", 32'(ir), 32'h00);
    chk("mid_rst_cb", 32'(cb), 32'h0);
    chk("mid_rst_m", 32'(m_cycle), 32'h0);
    chk("mid_rst_t", 32'(t_phase), 32'h0);
    chk("mid_rst_halted", 32'(halted), 32'h0);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0000);
    chk("mid_rst_rd", 32'(mem_rd), 32'h1);
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
